// File: rtl/mips_fetch_stage_pkg.sv
// Shared types and constants for the MIPS instruction-fetch stage:
// fetch-control state encoding, IF/ID register layout and bubble value.
`timescale 1ns/1ps
package mips_fetch_stage_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_DRAIN = 2'b01,
        ST_DONE  = 2'b10
    } fetch_state_e;

    localparam logic [31:0] DEFAULT_HALT_INS = 32'hFFFF_FFFF;

    // sll $0,$0,0 -- the canonical MIPS nop doubles as the pipeline bubble.
    localparam logic [31:0] BUBBLE_INS = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] pc4;
        logic        valid;
    } ifid_t;

    localparam ifid_t IFID_BUBBLE = '{ins: BUBBLE_INS, pc4: 32'h0000_0000, valid: 1'b0};

    function automatic ifid_t ifid_fetch(input logic [31:0] ins, input logic [31:0] pc4);
        ifid_t r;
        r.ins   = ins;
        r.pc4   = pc4;
        r.valid = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/mips_pc_reg.sv
// Program counter: async active-low clear to RESET_PC, with load (redirect),
// hold, and default sequential increment by one word (wraps modulo 2^32).
`timescale 1ns/1ps
module mips_pc_reg #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic        hold_i,
    input  logic [31:0] load_pc_i,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;

    assign pc_plus4_o = pc_q + 32'd4;
    assign pc_o       = pc_q;

    always_comb begin
        pc_d = pc_plus4_o;
        if (load_i) begin
            pc_d = load_pc_i;
        end else if (hold_i) begin
            pc_d = pc_q;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/mips_fetch_stage.sv
// MIPS IF stage: PC sequencing, IF/ID pipeline register and the halt/drain
// controller that raises a sticky fin once older instructions have retired.
`timescale 1ns/1ps
module mips_fetch_stage
    import mips_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] HALT_INS = DEFAULT_HALT_INS,
    parameter int unsigned DRAIN    = 4
) (
    input  logic        clk,
    input  logic        pcclr,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        stall,
    input  logic        flush,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic [31:0] ifid_ins,
    output logic [31:0] ifid_pc4,
    output logic        ifid_valid,
    output logic        fin
);

    localparam int CNT_W = (DRAIN > 1) ? $clog2(DRAIN) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DRAIN - 1);

    fetch_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    ifid_t            ifid_q, ifid_d;
    logic             fin_q, fin_d;

    logic        pc_load;
    logic        pc_hold;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        halt_go;

    mips_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk        (clk),
        .rst_n      (pcclr),
        .load_i     (pc_load),
        .hold_i     (pc_hold),
        .load_pc_i  (br_target),
        .pc_o       (pc),
        .pc_plus4_o (pc_plus4)
    );

    // Halt only counts once it actually leaves IF/ID into ID on a clean cycle.
    assign halt_go = ifid_q.valid && (ifid_q.ins == HALT_INS)
                     && !stall && !flush && !br_taken;

    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ifid_d  = ifid_q;
        fin_d   = fin_q;
        pc_load = 1'b0;
        pc_hold = 1'b0;

        unique case (state_q)
            ST_RUN: begin
                if (br_taken) begin
                    pc_load = 1'b1;
                    ifid_d  = IFID_BUBBLE;
                end else if (halt_go) begin
                    // The word fetched behind the halt is never issued.
                    pc_hold = 1'b1;
                    ifid_d  = IFID_BUBBLE;
                    state_d = ST_DRAIN;
                    cnt_d   = CNT_LOAD;
                end else begin
                    pc_hold = stall;
                    if (flush) begin
                        ifid_d = IFID_BUBBLE;
                    end else if (!stall) begin
                        ifid_d = ifid_fetch(imem_data, pc_plus4);
                    end
                end
            end

            ST_DRAIN: begin
                ifid_d = IFID_BUBBLE;
                if (br_taken) begin
                    // Halt sat on a mispredicted path: resume at the target.
                    pc_load = 1'b1;
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    pc_hold = 1'b1;
                    if (cnt_q == '0) begin
                        state_d = ST_DONE;
                        fin_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end

            ST_DONE: begin
                pc_hold = 1'b1;
            end

            default: begin
                pc_hold = 1'b1;
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge pcclr) begin
        if (!pcclr) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            ifid_q  <= IFID_BUBBLE;
            fin_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ifid_q  <= ifid_d;
            fin_q   <= fin_d;
        end
    end

    assign imem_addr  = pc;
    assign ifid_ins   = ifid_q.ins;
    assign ifid_pc4   = ifid_q.pc4;
    assign ifid_valid = ifid_q.valid;
    assign fin        = fin_q;

endmodule

// File: tb/tb_mips_fetch_stage.sv
// Self-checking bench for mips_fetch_stage: directed scenarios plus a random
// phase, all compared against a cycle-level behavioural model of the stage.
`timescale 1ns/1ps
module tb_mips_fetch_stage;

    localparam logic [31:0] HALT      = 32'hFFFF_FFFF;
    localparam int          DRAIN_CYC = 4;

    logic        clk;
    logic        pcclr;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        stall;
    logic        flush;
    logic        br_taken;
    logic [31:0] br_target;
    logic [31:0] ifid_ins;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;
    logic        fin;

    logic [31:0] mem [0:63];

    int checks = 0;
    int errors = 0;

    // Behavioural model of the stage's architectural state.
    logic [31:0] m_pc;
    logic [31:0] m_ins;
    logic [31:0] m_pc4;
    logic        m_valid;
    logic        m_fin;
    logic        m_done;
    int          m_drain_left;

    mips_fetch_stage dut (
        .clk        (clk),
        .pcclr      (pcclr),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .stall      (stall),
        .flush      (flush),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .ifid_ins   (ifid_ins),
        .ifid_pc4   (ifid_pc4),
        .ifid_valid (ifid_valid),
        .fin        (fin)
    );

    assign imem_data = mem[imem_addr[7:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".addr"},  imem_addr,          m_pc);
        check({tag, ".ins"},   ifid_ins,           m_ins);
        check({tag, ".pc4"},   ifid_pc4,           m_pc4);
        check({tag, ".valid"}, {31'b0, ifid_valid}, {31'b0, m_valid});
        check({tag, ".fin"},   {31'b0, fin},        {31'b0, m_fin});
    endtask

    task automatic model_reset();
        m_pc         = 32'h0;
        m_ins        = 32'h0;
        m_pc4        = 32'h0;
        m_valid      = 1'b0;
        m_fin        = 1'b0;
        m_done       = 1'b0;
        m_drain_left = 0;
    endtask

    task automatic model_bubble();
        m_ins   = 32'h0;
        m_pc4   = 32'h0;
        m_valid = 1'b0;
    endtask

    // One rising edge of the fetch stage, given this cycle's control inputs.
    task automatic model_step(input logic st, input logic fl, input logic br,
                              input logic [31:0] tgt);
        logic [31:0] word;
        word = mem[m_pc[7:2]];
        if (m_done) return;
        if (m_drain_left > 0) begin
            model_bubble();
            if (br) begin
                m_pc         = tgt;
                m_drain_left = 0;
            end else begin
                m_drain_left = m_drain_left - 1;
                if (m_drain_left == 0) begin
                    m_done = 1'b1;
                    m_fin  = 1'b1;
                end
            end
            return;
        end
        if (br) begin
            m_pc = tgt;
            model_bubble();
        end else if (m_valid && m_ins == HALT && !st && !fl) begin
            model_bubble();
            m_drain_left = DRAIN_CYC;
        end else if (fl) begin
            model_bubble();
            if (!st) m_pc = m_pc + 32'd4;
        end else if (!st) begin
            m_ins   = word;
            m_pc4   = m_pc + 32'd4;
            m_valid = 1'b1;
            m_pc    = m_pc + 32'd4;
        end
    endtask

    task automatic tick(input logic st, input logic fl, input logic br,
                        input logic [31:0] tgt, input string tag);
        @(negedge clk);
        stall     = st;
        flush     = fl;
        br_taken  = br;
        br_target = tgt;
        model_step(st, fl, br, tgt);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic run(input int n, input string tag);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 32'h0, $sformatf("%s%0d", tag, i));
    endtask

    // Assert reset mid-cycle, check outputs while still in reset, release after an edge.
    task automatic do_reset(input string tag);
        @(negedge clk);
        #2;
        pcclr     = 1'b0;
        stall     = 1'b0;
        flush     = 1'b0;
        br_taken  = 1'b0;
        br_target = 32'h0;
        #1;
        model_reset();
        check_all(tag);
        @(posedge clk);
        #1;
        check_all({tag, ".held"});
        pcclr = 1'b1;
    endtask

    task automatic fill_mem();
        for (int i = 0; i < 64; i++) mem[i] = $urandom & 32'h7FFF_FFFF;
    endtask

    initial begin
        pcclr     = 1'b0;
        stall     = 1'b0;
        flush     = 1'b0;
        br_taken  = 1'b0;
        br_target = 32'h0;
        fill_mem();
        model_reset();

        do_reset("rst0");

        // Free-running fetch of three words.
        mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33;
        run(3, "seq");
        check("seq.ins3", ifid_ins, 32'h33);
        check("seq.pc4_3", ifid_pc4, 32'd12);

        // Stall for two cycles with PC at 8, then stall+flush together.
        do_reset("rst1");
        run(2, "pre_stall");
        tick(1'b1, 1'b0, 1'b0, 32'h0, "stall0");
        tick(1'b1, 1'b0, 1'b0, 32'h0, "stall1");
        check("stall.pc", imem_addr, 32'h8);
        check("stall.ins", ifid_ins, 32'h22);
        tick(1'b0, 1'b0, 1'b0, 32'h0, "resume");
        check("resume.ins", ifid_ins, 32'h33);
        tick(1'b1, 1'b1, 1'b0, 32'h0, "stall_flush");
        check("stall_flush.valid", {31'b0, ifid_valid}, 32'h0);
        check("stall_flush.pc", imem_addr, 32'hC);

        // Branch redirect from PC 0x10 to 0x40.
        do_reset("rst2");
        run(4, "pre_br");
        tick(1'b0, 1'b0, 1'b1, 32'h40, "br");
        check("br.pc", imem_addr, 32'h40);
        check("br.bubble", {31'b0, ifid_valid}, 32'h0);
        tick(1'b0, 1'b0, 1'b0, 32'h0, "br_fetch");
        check("br_fetch.ins", ifid_ins, mem[16]);
        check("br_fetch.pc4", ifid_pc4, 32'h44);

        // Halt at 0x0C: fin exactly DRAIN edges after halt leaves IF/ID.
        do_reset("rst3");
        mem[3] = HALT;
        run(4, "pre_halt");
        check("halt.in_ifid", ifid_ins, HALT);
        tick(1'b0, 1'b0, 1'b0, 32'h0, "halt_adv");
        for (int i = 1; i < DRAIN_CYC; i++) begin
            tick(1'b0, 1'b0, 1'b0, 32'h0, $sformatf("drain%0d", i));
            check($sformatf("drain%0d.fin", i), {31'b0, fin}, 32'h0);
        end
        tick(1'b0, 1'b0, 1'b0, 32'h0, "done");
        check("done.fin", {31'b0, fin}, 32'h1);
        check("done.pc", imem_addr, 32'h10);
        for (int i = 0; i < 4; i++)
            tick($urandom_range(1), $urandom_range(1), $urandom_range(1),
                 $urandom & 32'hFFFF_FFFC, $sformatf("frozen%0d", i));

        // Branch during the second drain cycle cancels the halt.
        do_reset("rst4");
        run(6, "pre_cancel");
        tick(1'b0, 1'b0, 1'b1, 32'h20, "cancel");
        check("cancel.fin", {31'b0, fin}, 32'h0);
        tick(1'b0, 1'b0, 1'b0, 32'h0, "cancel_fetch");
        check("cancel_fetch.ins", ifid_ins, mem[8]);
        check("cancel_fetch.pc4", ifid_pc4, 32'h24);
        run(4, "post_cancel");

        // Reset mid-drain, then again once done.
        do_reset("rst5");
        run(7, "to_drain");
        do_reset("rst_mid_drain");
        tick(1'b0, 1'b0, 1'b0, 32'h0, "refetch0");
        check("refetch0.ins", ifid_ins, mem[0]);
        run(10, "to_done");
        check("to_done.fin", {31'b0, fin}, 32'h1);
        do_reset("rst_done");
        check("rst_done.fin", {31'b0, fin}, 32'h0);
        tick(1'b0, 1'b0, 1'b0, 32'h0, "refetch1");

        // PC wraps from the top of the address space.
        mem[3] = 32'h0000_1234;
        tick(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, "to_top");
        tick(1'b0, 1'b0, 1'b0, 32'h0, "wrap");
        check("wrap.pc4", ifid_pc4, 32'h0);
        check("wrap.pc", imem_addr, 32'h0);

        // Random control traffic with halts sprinkled through memory.
        for (int i = 0; i < 64; i++)
            mem[i] = ($urandom_range(11) == 0) ? HALT : ($urandom & 32'h7FFF_FFFF);
        for (int i = 0; i < 600; i++) begin
            if (m_done && $urandom_range(5) == 0) begin
                do_reset($sformatf("rnd_rst%0d", i));
            end else begin
                tick($urandom_range(3) == 0, $urandom_range(7) == 0,
                     $urandom_range(9) == 0, $urandom & 32'hFFFF_FFFC,
                     $sformatf("rnd%0d", i));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
